// File: rtl/ps2_pkg.sv
// Shared definitions for the PS/2 host transmitter: state encoding, error codes,
// common keyboard command bytes and the frame builder.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    INHIBIT  = 3'd1,
    REQ_GAP  = 3'd2,
    XMIT     = 3'd3,
    ACK      = 3'd4,
    WAIT_REL = 3'd5,
    ERR      = 3'd6
  } ps2_state_e;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_TIMEOUT = 2'b01;
  localparam logic [1:0] ERR_NACK    = 2'b10;

  localparam logic [7:0] CMD_SET_LED = 8'hED;
  localparam logic [7:0] CMD_ENABLE  = 8'hF4;
  localparam logic [7:0] CMD_RESET   = 8'hFF;

  // Shift frame, bit 0 goes out first: data LSB first, odd parity, stop.
  function automatic logic [9:0] make_frame(input logic [7:0] data);
    return {1'b1, ~^data, data};
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Multi-stage synchroniser for one raw PS/2 line, plus a one-cycle strobe
// on each high-to-low transition of the synchronised level.
module ps2_line_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Idle PS/2 lines float high, so reset to 1 to avoid a spurious fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], din};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign level = sync_q[SYNC_STAGES-1];
  assign fall  = prev_q & ~level;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, issues request-to-send,
// shifts one command byte out on device clock falls and checks the device ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 10000,
  parameter int TIMEOUT_CYCLES = 2000000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] err_code,
  input  logic       ps2_clk_in,
  input  logic       ps2_data_in,
  output logic       ps2_clk_oe,
  output logic       ps2_data_oe
);

  // Handshake: a byte is accepted on a clock edge where tx_valid && tx_ready;
  // tx_ready is high only in IDLE and tx_valid is ignored everywhere else.

  localparam int TMAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);
  localparam logic [TW-1:0] INH_LAST  = TW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] WDOG_LAST = TW'(TIMEOUT_CYCLES - 1);

  ps2_state_e    state_q, state_d;
  logic [TW-1:0] timer_q, timer_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic [9:0]    frame_q, frame_d;
  logic          ack_q, ack_d;
  logic          clk_oe_d, data_oe_d, done_d, err_d, ready_d;
  logic [1:0]    err_code_d;

  logic clk_s, clk_fall, data_s, data_fall_unused;
  logic wdog_expired;

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_clk_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (ps2_clk_in),
    .level (clk_s),
    .fall  (clk_fall)
  );

  ps2_line_sync #(.SYNC_STAGES(SYNC_STAGES)) u_data_sync (
    .clk   (clk),
    .rst   (rst),
    .din   (ps2_data_in),
    .level (data_s),
    .fall  (data_fall_unused)
  );

  // One timer serves as the inhibit counter and, from XMIT on, the watchdog.
  assign wdog_expired = (timer_q == WDOG_LAST);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      timer_q     <= '0;
      bit_cnt_q   <= '0;
      frame_q     <= '0;
      ack_q       <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
      tx_done     <= 1'b0;
      tx_err      <= 1'b0;
      tx_ready    <= 1'b1;
      err_code    <= ERR_NONE;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      bit_cnt_q   <= bit_cnt_d;
      frame_q     <= frame_d;
      ack_q       <= ack_d;
      ps2_clk_oe  <= clk_oe_d;
      ps2_data_oe <= data_oe_d;
      tx_done     <= done_d;
      tx_err      <= err_d;
      tx_ready    <= ready_d;
      err_code    <= err_code_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q;
    bit_cnt_d  = bit_cnt_q;
    frame_d    = frame_q;
    ack_d      = ack_q;
    clk_oe_d   = 1'b0;
    data_oe_d  = 1'b0;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code;

    case (state_q)
      IDLE: begin
        timer_d = '0;
        if (tx_valid && tx_ready) begin
          frame_d  = make_frame(tx_data);
          clk_oe_d = 1'b1;
          state_d  = INHIBIT;
        end
      end
      INHIBIT: begin
        clk_oe_d = 1'b1;
        if (timer_q == INH_LAST) begin
          timer_d   = '0;
          data_oe_d = 1'b1;
          state_d   = REQ_GAP;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      // Data already low, clock released this edge: request-to-send.
      REQ_GAP: begin
        data_oe_d = 1'b1;
        bit_cnt_d = '0;
        timer_d   = '0;
        state_d   = XMIT;
      end
      XMIT: begin
        data_oe_d = ps2_data_oe;
        if (wdog_expired) begin
          data_oe_d  = 1'b0;
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ERR;
        end else begin
          timer_d = timer_q + TW'(1);
          if (clk_fall) begin
            if (bit_cnt_q == 4'd10) begin
              ack_d     = data_s;
              data_oe_d = 1'b0;
              state_d   = ACK;
            end else begin
              data_oe_d = ~frame_q[bit_cnt_q];
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end
      ACK: begin
        if (wdog_expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ERR;
        end else begin
          timer_d = timer_q + TW'(1);
          if (!ack_q) begin
            state_d = WAIT_REL;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_NACK;
            state_d    = ERR;
          end
        end
      end
      WAIT_REL: begin
        if (wdog_expired) begin
          err_d      = 1'b1;
          err_code_d = ERR_TIMEOUT;
          state_d    = ERR;
        end else begin
          timer_d = timer_q + TW'(1);
          if (clk_s && data_s) begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
      end
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ready_d = (state_d == IDLE);
  end

endmodule

// File: tb/tb_ps2_host_tx.sv
// Bench for ps2_host_tx: open-drain bus with a PS/2 device model, a cycle-level
// reference model of the host outputs, and frame/result scoreboards.
module tb_ps2_host_tx;
  import ps2_pkg::*;

  localparam int INH  = 20;
  localparam int TMO  = 5000;
  localparam int HALF = 40;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, tx_done, tx_err;
  logic [1:0] err_code;
  logic       ps2_clk_in, ps2_data_in, ps2_clk_oe, ps2_data_oe;
  logic       dev_clk_low = 1'b0;
  logic       dev_data_low = 1'b0;

  assign ps2_clk_in  = ~(ps2_clk_oe | dev_clk_low);
  assign ps2_data_in = ~(ps2_data_oe | dev_data_low);

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .TIMEOUT_CYCLES (TMO),
    .SYNC_STAGES    (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .tx_data     (tx_data),
    .tx_valid    (tx_valid),
    .tx_ready    (tx_ready),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .err_code    (err_code),
    .ps2_clk_in  (ps2_clk_in),
    .ps2_data_in (ps2_data_in),
    .ps2_clk_oe  (ps2_clk_oe),
    .ps2_data_oe (ps2_data_oe)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [9:0] ref_frame(input logic [7:0] b);
    logic par;
    par = (($countones(b) % 2) == 0);
    return {1'b1, par, b};
  endfunction

  logic [9:0] exp_frame_q[$];
  logic [1:0] exp_q[$];
  bit         busy = 1'b0;
  bit         err_tail = 1'b0;
  logic [1:0] exp_code = 2'b00;
  int         cyc = 0;
  int         acc_cyc = 0;
  int         n_pulse = 0;
  int         n_done = 0;

  always @(posedge clk) begin
    cyc++;
    if (rst && !busy && tx_valid) begin
      busy    = 1'b1;
      acc_cyc = cyc;
      exp_frame_q.push_back(ref_frame(tx_data));
    end
  end

  always @(negedge clk) begin
    int k;
    logic [1:0] r;
    if (!rst) begin
      busy = 1'b0;
      err_tail = 1'b0;
      exp_code = 2'b00;
      exp_q.delete();
      exp_frame_q.delete();
      check("rst_ready", tx_ready, 1);
      check("rst_oe", {ps2_clk_oe, ps2_data_oe}, 0);
      check("rst_pulses", {tx_done, tx_err}, 0);
      check("rst_code", err_code, 0);
    end else begin
      if (err_tail) begin
        busy = 1'b0;
        err_tail = 1'b0;
      end
      k = cyc - acc_cyc;
      check("done_err_excl", tx_done & tx_err, 0);
      if (tx_done || tx_err) begin
        n_pulse++;
        if (tx_done) n_done++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pulse done=%0b err=%0b code=%0b", tx_done, tx_err, err_code);
        end else begin
          r = exp_q.pop_front();
          check("result_done", tx_done, (r == ERR_NONE));
          check("result_err", tx_err, (r != ERR_NONE));
          if (r != ERR_NONE) exp_code = r;
          if (r == ERR_TIMEOUT) check("timeout_latency", k, INH + 1 + TMO);
        end
        if (tx_done) busy = 1'b0;
        else begin
          err_tail = 1'b1;
          check("ready_in_err", tx_ready, 0);
          check("err_oe", {ps2_clk_oe, ps2_data_oe}, 0);
        end
      end else begin
        check("ready", tx_ready, !busy);
      end
      check("err_code", err_code, exp_code);
      if (!busy) check("idle_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
      else if (k < INH) check("inhibit_oe", {ps2_clk_oe, ps2_data_oe}, 2'b10);
      else if (k == INH) check("req_gap_oe", {ps2_clk_oe, ps2_data_oe}, 2'b11);
      else if (k == INH + 1) check("release_oe", {ps2_clk_oe, ps2_data_oe}, 2'b01);
      else check("xmit_clk_oe", ps2_clk_oe, 0);
    end
  end

  // ---------------- driver / device tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic [1:0] res);
    exp_q.push_back(res);
    @(posedge clk);
    #1;
    tx_data  = b;
    tx_valid = 1'b1;
    @(posedge clk);
    #1;
    tx_valid = 1'b0;
    tx_data  = 8'($urandom_range(0, 255));
  endtask

  // mode 0 = ack, 1 = no ack, 2 = reset at bit 4, 3 = never clock
  task automatic dev_run(input int mode, output logic [9:0] bits);
    int t;
    bits = '0;
    t = 0;
    while (!(ps2_clk_in === 1'b1 && ps2_data_in === 1'b0) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("request_seen", (t < 200), 1);
    if (t >= 200 || mode == 3) return;
    wait_cycles($urandom_range(5, 30));
    for (int i = 0; i < 10; i++) begin
      dev_clk_low = 1'b1;
      if (mode == 2 && i == 4) begin
        wait_cycles(HALF / 2);
        check("abort_pre_data_oe", ps2_data_oe, 1);
        #2;
        rst = 1'b0;
        #1;
        check("abort_clk_oe", ps2_clk_oe, 0);
        check("abort_data_oe", ps2_data_oe, 0);
        check("abort_ready", tx_ready, 1);
        dev_clk_low = 1'b0;
        wait_cycles(3);
        rst = 1'b1;
        return;
      end
      wait_cycles(HALF);
      bits[i] = ps2_data_in;
      dev_clk_low = 1'b0;
      wait_cycles((i == 9) ? HALF / 2 : HALF);
    end
    if (exp_frame_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL frame_unexpected bits=%0h", bits);
    end else begin
      check("frame", bits, exp_frame_q.pop_front());
    end
    if (mode == 0) dev_data_low = 1'b1;
    wait_cycles(HALF / 2);
    dev_clk_low = 1'b1;
    wait_cycles(HALF);
    dev_clk_low = 1'b0;
    wait_cycles(10);
    dev_data_low = 1'b0;
  endtask

  task automatic wait_pulse(input int prev, input int budget);
    int t;
    t = 0;
    while (n_pulse == prev && t < budget) begin
      @(negedge clk);
      t++;
    end
    check("pulse_seen", (n_pulse > prev), 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [9:0] bits;
    logic [7:0] b;
    bit         nack;
    int         p, d;

    wait_cycles(3);
    check("reset_ready", tx_ready, 1);
    check("reset_code", err_code, 2'b00);
    rst = 1'b1;
    wait_cycles(3);

    p = n_pulse;
    send(CMD_SET_LED, ERR_NONE);
    dev_run(0, bits);
    check("ed_bits", bits, 10'h3ED);
    wait_pulse(p, 100);
    check("ed_code", err_code, 2'b00);

    p = n_pulse;
    send(CMD_ENABLE, ERR_NONE);
    dev_run(0, bits);
    check("f4_bits", bits, 10'h2F4);
    wait_pulse(p, 100);

    p = n_pulse;
    send(8'h00, ERR_NONE);
    dev_run(0, bits);
    check("00_bits", bits, 10'h300);
    wait_pulse(p, 100);

    p = n_pulse;
    send(8'hA5, ERR_TIMEOUT);
    dev_run(3, bits);
    wait_pulse(p, TMO + 200);
    wait_cycles(2);
    check("timeout_code", err_code, 2'b01);
    check("timeout_oe", {ps2_clk_oe, ps2_data_oe}, 2'b00);
    check("timeout_ready", tx_ready, 1);
    exp_frame_q.delete();

    p = n_pulse;
    d = n_done;
    send(8'h3C, ERR_NACK);
    dev_run(1, bits);
    wait_pulse(p, 100);
    check("nack_code", err_code, 2'b10);
    check("nack_no_done", n_done - d, 0);

    send(CMD_SET_LED, ERR_NONE);
    dev_run(2, bits);
    wait_cycles(5);
    p = n_pulse;
    send(CMD_RESET, ERR_NONE);
    dev_run(0, bits);
    check("ff_bits", bits, 10'h3FF);
    wait_pulse(p, 100);

    p = n_pulse;
    d = n_done;
    send(8'hC3, ERR_NONE);
    wait_cycles(5);
    tx_data  = 8'h55;
    tx_valid = 1'b1;
    wait_cycles(10);
    tx_valid = 1'b0;
    dev_run(0, bits);
    check("busy_bits", bits, 10'h3C3);
    wait_pulse(p, 100);
    wait_cycles(100);
    check("busy_one_done", n_done - d, 1);

    for (int i = 0; i < 8; i++) begin
      b    = 8'($urandom_range(0, 255));
      nack = ($urandom_range(0, 3) == 0);
      p    = n_pulse;
      send(b, nack ? ERR_NACK : ERR_NONE);
      dev_run(nack ? 1 : 0, bits);
      check("rand_bits", bits, ref_frame(b));
      wait_pulse(p, 100);
      wait_cycles($urandom_range(1, 20));
    end

    wait_cycles(20);
    check("results_drained", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL global_timeout checks=%0d errors=%0d", checks, errors);
    $fatal(1, "bench did not finish");
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
PS/2 host-to-device transmitter. It sends one command byte (for example 0xED set-LEDs, 0xF4 enable, 0xFF reset) to the keyboard over the same PS2_CLK/PS2_DATA lines that KeyboardDecoder receives on. It sits beside KeyboardDecoder in the top level. The top level converts its open-drain enables to tri-states: line = oe ? 1'b0 : 1'bz.

Parameters:
INHIBIT_CYCLES, 10000, clk cycles the host holds PS2_CLK low before the request (100 us at 100 MHz).
TIMEOUT_CYCLES, 2000000, maximum clk cycles from request release to ack completion (20 ms).
SYNC_STAGES, 2, flip-flop stages on each sampled PS/2 line.

Ports:
clk  in  1  system clock, 100 MHz.
rst  in  1  asynchronous reset, active-low (asserted when 0).
tx_data  in  8  command byte, sampled at accept.
tx_valid  in  1  request; a byte is accepted when tx_valid && tx_ready.
tx_ready  out  1  high only in IDLE.
tx_done  out  1  one-cycle pulse: byte sent and device ack received.
tx_err  out  1  one-cycle pulse: transfer aborted.
err_code  out  2  valid with tx_err; 01 = timeout, 10 = no ack; holds its value until the next error.
ps2_clk_in  in  1  raw PS2_CLK pin level.
ps2_data_in  in  1  raw PS2_DATA pin level.
ps2_clk_oe  out  1  1 = drive PS2_CLK low.
ps2_data_oe  out  1  1 = drive PS2_DATA low.

Behaviour:
- Reset (rst=0), immediate and asynchronous: state=IDLE, ps2_clk_oe=0, ps2_data_oe=0, tx_ready=1, tx_done=0, tx_err=0, err_code=00, all counters 0. Reset mid-transfer releases both lines at once; no partial retry.
- Input sampling: both lines pass through SYNC_STAGES flip-flops. fall = previous synchronised ps2_clk was 1 and current is 0; this is a one-cycle strobe.
- Shift frame: 10 bits, tx_data[0..7] LSB first, then odd parity (parity = ~^tx_data), then stop = 1. The frame is latched at accept.
- IDLE: tx_ready=1. On accept, go to INHIBIT on the next edge and drop tx_ready in the same edge. tx_valid is ignored in every other state. The line state is not checked; inhibit deliberately aborts any device transmission in progress.
- INHIBIT: ps2_clk_oe=1, ps2_data_oe=0. Count INHIBIT_CYCLES. At terminal count: ps2_data_oe=1, then one cycle later ps2_clk_oe=0. This is the start bit / request-to-send. Go to XMIT, set bit_cnt=0, clear the watchdog.
- XMIT: on each fall, bit_cnt increments.
  - bit_cnt 0..8 → ps2_data_oe = ~frame[bit_cnt] (data and parity).
  - bit_cnt 9 → ps2_data_oe=0 (stop, line released).
  - The data change happens within 1 clk of the synchronised fall, while the device clock is low.
  - The fall after the stop bit (the 11th fall) goes to ACK.
- ACK: sample synchronised data at that 11th fall. If 0, go to WAIT_REL. If 1, go to ERR with err_code=10.
- WAIT_REL: wait until synchronised clk==1 and data==1, then go to IDLE. tx_done pulses on that transition edge and tx_ready=1 from the next cycle.
- Watchdog: runs in XMIT, ACK and WAIT_REL. When it reaches TIMEOUT_CYCLES, go to ERR with err_code=01. Timeout takes priority over a simultaneous fall.
- ERR: lasts one cycle. Both oe=0, tx_err=1, then IDLE.
- tx_done and tx_err are never high in the same cycle.
- All outputs are registered; there is no combinational path from input to output.

Decomposition:
- Shared package ps2_pkg holds:
  - state encoding: IDLE, INHIBIT, REQ_GAP, XMIT, ACK, WAIT_REL, ERR;
  - err_code constants ERR_TIMEOUT=2'b01, ERR_NACK=2'b10;
  - command constants CMD_SET_LED=8'hED, CMD_ENABLE=8'hF4, CMD_RESET=8'hFF.
- One sub-module, ps2_line_sync: synchroniser plus fall-edge detector, instantiated for PS2_CLK and PS2_DATA (the data instance does not use its fall output).

Test Plan:
(The bench overrides INHIBIT_CYCLES=20 and TIMEOUT_CYCLES=5000. The device model clocks at 40-cycle half-periods and samples on rising edges.)
- Send 0xED → bits on the device side are 1,0,1,1,0,1,1,1, parity=1, stop=1; device acks → tx_done pulses once, err_code=00.
- Send 0xF4 → parity bit=0. Send 0x00 → parity bit=1. Both finish with tx_done.
- No device clocks after request → tx_err with err_code=01, 5000 cycles after request release; both oe=0 afterwards; tx_ready=1.
- Device leaves data high at the 11th clock → tx_err with err_code=10; no tx_done.
- Assert rst=0 mid-XMIT at bit 4 → ps2_clk_oe=0 and ps2_data_oe=0 in the same cycle; after release tx_ready=1 and the next 0xFF transfer completes normally.
- Raise tx_valid with 0x55 while busy → ignored; only the original byte appears on the line; exactly one tx_done.
